// File: rtl/escalonador_sensor.sv
// escalonador_sensor: sequences host requests and continuous-mode reads onto the
// single-sensor link, enforcing DHT11 read spacing and recovering from sensor timeouts.
module escalonador_sensor #(
  parameter logic [7:0]  SENSOR_ADDR    = 8'h01,
  parameter int unsigned MIN_GAP_CYCLES = 50_000_000,
  parameter int unsigned PERIOD_CYCLES  = 100_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 10_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [7:0] req_command,
  input  logic [7:0] req_address,
  output logic       req_ready,
  output logic       sens_enable,
  output logic [7:0] sens_command,
  output logic [7:0] sens_address,
  output logic       sens_reset,
  input  logic       sens_done,
  input  logic [7:0] sens_resp_command,
  input  logic [7:0] sens_resp_value,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic [7:0] tx_command,
  output logic [7:0] tx_value,
  output logic       cont_active
);

  typedef enum logic [2:0] {IDLE, GAP, ISSUE, WAIT_RESP, RECOVER, SEND} state_t;
  state_t state, state_next;

  logic        hold_valid;
  logic [7:0]  hold_cmd, hold_addr;
  logic [7:0]  cur_cmd, next_cmd, cont_cmd;
  logic        tick;
  logic [31:0] per_cnt, gap_cnt, to_cnt;
  logic [2:0]  rec_cnt;

  logic        take_req, take_tick, local_reply, start_cont, stop_cont;
  logic        issue, got_resp, timed_out, rec_done, send_now;
  logic [7:0]  reply_cmd, reply_val;

  assign req_ready = ~hold_valid;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    take_req    = 1'b0;
    take_tick   = 1'b0;
    local_reply = 1'b0;
    start_cont  = 1'b0;
    stop_cont   = 1'b0;
    issue       = 1'b0;
    got_resp    = 1'b0;
    timed_out   = 1'b0;
    rec_done    = 1'b0;
    send_now    = 1'b0;
    reply_cmd   = '0;
    reply_val   = '0;
    next_cmd    = cur_cmd;
    case (state)
      IDLE: begin
        // Host requests win over a pending continuous tick; the tick stays pending.
        if (hold_valid) begin
          take_req = 1'b1;
          if (hold_addr != SENSOR_ADDR) begin
            local_reply = 1'b1;
            reply_cmd   = 8'hEF;
            reply_val   = 8'hEF;
            state_next  = SEND;
          end else if (hold_cmd == 8'h05 || hold_cmd == 8'h06) begin
            local_reply = 1'b1;
            state_next  = SEND;
            if (cont_active) begin
              stop_cont = 1'b1;
              reply_cmd = (hold_cmd == 8'h05) ? 8'h0A : 8'h0B;
              reply_val = 8'h00;
            end else begin
              reply_cmd = 8'hAA;
              reply_val = 8'hAA;
            end
          end else if (cont_active) begin
            local_reply = 1'b1;
            reply_cmd   = 8'hFF;
            reply_val   = 8'hFF;
            state_next  = SEND;
          end else if (hold_cmd == 8'h03 || hold_cmd == 8'h04) begin
            start_cont = 1'b1;
            next_cmd   = hold_cmd - 8'h02;
            state_next = GAP;
          end else begin
            next_cmd   = hold_cmd;
            state_next = GAP;
          end
        end else if (tick) begin
          take_tick  = 1'b1;
          next_cmd   = cont_cmd;
          state_next = GAP;
        end
      end
      GAP: begin
        if (gap_cnt >= MIN_GAP_CYCLES) state_next = ISSUE;
      end
      ISSUE: begin
        issue      = 1'b1;
        state_next = WAIT_RESP;
      end
      WAIT_RESP: begin
        if (sens_done) begin
          got_resp   = 1'b1;
          state_next = SEND;
        end else if (to_cnt == TIMEOUT_CYCLES - 1) begin
          timed_out  = 1'b1;
          state_next = RECOVER;
        end
      end
      RECOVER: begin
        if (rec_cnt == 3'd7) begin
          rec_done   = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          send_now   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_valid   <= 1'b0;
      hold_cmd     <= '0;
      hold_addr    <= '0;
      cur_cmd      <= '0;
      cont_cmd     <= '0;
      cont_active  <= 1'b0;
      tick         <= 1'b0;
      per_cnt      <= '0;
      gap_cnt      <= MIN_GAP_CYCLES;
      to_cnt       <= '0;
      rec_cnt      <= '0;
      sens_enable  <= 1'b0;
      sens_command <= '0;
      sens_address <= '0;
      sens_reset   <= 1'b0;
      tx_start     <= 1'b0;
      tx_command   <= '0;
      tx_value     <= '0;
    end else begin
      tx_start <= send_now;
      cur_cmd  <= next_cmd;

      if (take_req) begin
        hold_valid <= 1'b0;
      end else if (req_valid && !hold_valid) begin
        hold_valid <= 1'b1;
        hold_cmd   <= req_command;
        hold_addr  <= req_address;
      end

      // Period counter restarts on each read issued in continuous mode and parks
      // at PERIOD_CYCLES once the tick is raised.
      if (stop_cont) begin
        cont_active <= 1'b0;
        tick        <= 1'b0;
        per_cnt     <= '0;
      end else begin
        if (start_cont) begin
          cont_active <= 1'b1;
          cont_cmd    <= next_cmd;
        end
        if (take_tick) tick <= 1'b0;
        if (cont_active) begin
          if (issue) begin
            per_cnt <= '0;
          end else if (per_cnt != PERIOD_CYCLES) begin
            per_cnt <= per_cnt + 32'd1;
            if (per_cnt == PERIOD_CYCLES - 1) tick <= 1'b1;
          end
        end
      end

      if (got_resp || timed_out)       gap_cnt <= '0;
      else if (gap_cnt < MIN_GAP_CYCLES) gap_cnt <= gap_cnt + 32'd1;

      if (issue)                   to_cnt <= '0;
      else if (state == WAIT_RESP) to_cnt <= to_cnt + 32'd1;

      if (timed_out)             rec_cnt <= '0;
      else if (state == RECOVER) rec_cnt <= rec_cnt + 3'd1;

      if (issue) begin
        sens_enable  <= 1'b1;
        sens_command <= cur_cmd;
        sens_address <= SENSOR_ADDR;
      end else if (got_resp || timed_out) begin
        sens_enable <= 1'b0;
      end

      if (timed_out)     sens_reset <= 1'b1;
      else if (rec_done) sens_reset <= 1'b0;

      if (local_reply) begin
        tx_command <= reply_cmd;
        tx_value   <= reply_val;
      end else if (got_resp) begin
        tx_command <= sens_resp_command;
        tx_value   <= sens_resp_value;
      end else if (timed_out) begin
        tx_command <= 8'h1F;
        tx_value   <= 8'h1F;
      end
    end
  end

endmodule
